// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the K&S datapath: fetch/decode/execute sequencing,
// RAM wait states, halt/resume handshake and a saturating retired-instruction counter.

package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_BOV,
        I_BNOV,
        I_HALT
    } decoded_instruction_type;
endpackage

module multicycle_control_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter bit          BRANCH_EN   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    input  logic                    resume,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    write_reg_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [CNT_WIDTH-1:0]    retired_count
);

    typedef enum logic [3:0] {
        FETCH,
        LATCH_IR,
        DECODE,
        MEM_WAIT,
        LOAD_WB,
        STORE_WR,
        ALU_WB,
        BRANCH_TAKE,
        HALTED
    } state_t;

    typedef struct packed {
        logic branch;
        logic pc_enable;
        logic ir_enable;
        logic write_reg_enable;
        logic addr_sel;
        logic c_sel;
        logic flags_reg_enable;
        logic ram_write_enable;
        logic halt;
    } ctrl_t;

    state_t      state;
    state_t      next_state;
    ctrl_t       ctrl_q;
    logic [1:0]  op_q;
    logic [3:0]  wait_cnt;
    logic        retires;

    // No branch condition tests the unsigned flag.
    logic        unused_flag;
    assign unused_flag = unsigned_overflow;

    function automatic logic [1:0] alu_op(decoded_instruction_type i);
        case (i)
            I_ADD:   return 2'b01;
            I_SUB:   return 2'b10;
            I_AND:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_alu(decoded_instruction_type i);
        return (i == I_ADD) || (i == I_SUB) || (i == I_AND) ||
               (i == I_OR)  || (i == I_MOVE);
    endfunction

    function automatic logic branch_taken(decoded_instruction_type i,
                                          logic z, logic n, logic v);
        logic t;
        case (i)
            I_BRANCH: t = 1'b1;
            I_BZERO:  t = z;
            I_BNZERO: t = ~z;
            I_BNEG:   t = n;
            I_BNNEG:  t = ~n;
            I_BOV:    t = v;
            I_BNOV:   t = ~v;
            default:  t = 1'b0;
        endcase
        return t && BRANCH_EN;
    endfunction

    // Control word of the state being entered; loaded in the same edge as the
    // state so every Moore output comes straight from a flop.
    function automatic ctrl_t moore_ctrl(state_t s, decoded_instruction_type i);
        ctrl_t c;
        c = '0;
        case (s)
            LATCH_IR: begin
                c.ir_enable = 1'b1;
                c.pc_enable = 1'b1;
            end
            MEM_WAIT: c.addr_sel = 1'b1;
            LOAD_WB: begin
                c.addr_sel         = 1'b1;
                c.write_reg_enable = 1'b1;
            end
            STORE_WR: begin
                c.addr_sel         = 1'b1;
                c.ram_write_enable = 1'b1;
            end
            ALU_WB: begin
                c.c_sel            = 1'b1;
                c.write_reg_enable = 1'b1;
                c.flags_reg_enable = (i != I_MOVE);
            end
            BRANCH_TAKE: begin
                c.branch    = 1'b1;
                c.pc_enable = 1'b1;
            end
            HALTED:  c.halt = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    next_state = LATCH_IR;
            LATCH_IR: next_state = DECODE;
            DECODE: begin
                case (decoded_instruction)
                    I_HALT:  next_state = HALTED;
                    I_LOAD:  next_state = (RAM_LATENCY > 0) ? MEM_WAIT : LOAD_WB;
                    I_STORE: next_state = STORE_WR;
                    I_ADD, I_SUB, I_AND, I_OR, I_MOVE: next_state = ALU_WB;
                    default: next_state = branch_taken(decoded_instruction, zero_op,
                                                       neg_op, signed_overflow)
                                          ? BRANCH_TAKE : FETCH;
                endcase
            end
            MEM_WAIT:    next_state = (wait_cnt <= 4'd1) ? LOAD_WB : MEM_WAIT;
            LOAD_WB:     next_state = FETCH;
            STORE_WR:    next_state = FETCH;
            ALU_WB:      next_state = FETCH;
            BRANCH_TAKE: next_state = FETCH;
            HALTED:      next_state = resume ? FETCH : HALTED;
            default:     next_state = FETCH;
        endcase
    end

    // Resume from HALTED is excluded: the HALT already retired on entry.
    assign retires = ((next_state == FETCH) &&
                      (state inside {DECODE, LOAD_WB, STORE_WR, ALU_WB, BRANCH_TAKE})) ||
                     ((next_state == HALTED) && (state != HALTED));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            ctrl_q        <= '0;
            op_q          <= '0;
            wait_cnt      <= '0;
            retired_count <= '0;
        end else begin
            state  <= next_state;
            ctrl_q <= moore_ctrl(next_state, decoded_instruction);
            op_q   <= (next_state == ALU_WB) ? alu_op(decoded_instruction) : 2'b00;

            if (state == DECODE && decoded_instruction == I_LOAD) begin
                wait_cnt <= 4'(RAM_LATENCY);
            end else if (state == MEM_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (retires && (retired_count != '1)) begin
                retired_count <= retired_count + CNT_WIDTH'(1);
            end
        end
    end

    assign branch           = ctrl_q.branch;
    assign pc_enable        = ctrl_q.pc_enable;
    assign ir_enable        = ctrl_q.ir_enable;
    assign write_reg_enable = ctrl_q.write_reg_enable;
    assign flags_reg_enable = ctrl_q.flags_reg_enable;
    assign ram_write_enable = ctrl_q.ram_write_enable;
    assign halt             = ctrl_q.halt;

    // DECODE presents the memory/ALU steering for the instruction in the IR so the
    // datapath has it a cycle early; every other state uses the registered copy.
    assign addr_sel  = ctrl_q.addr_sel |
                       ((state == DECODE) &&
                        (decoded_instruction == I_LOAD || decoded_instruction == I_STORE));
    assign c_sel     = ctrl_q.c_sel | ((state == DECODE) && is_alu(decoded_instruction));
    assign operation = (state == DECODE) ? alu_op(decoded_instruction) : op_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised scoreboard bench: a per-instruction reference of latency, pulse counts
// and retire count, compared against windows observed between ir_enable pulses.

module tb_multicycle_control_unit;
    import k_and_s_pkg::*;

    localparam int N_REC = 150;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit pre_reset_phase = 1'b1;

    typedef struct {
        int lat;
        int pc;
        int wr;
        int ram;
        int flg;
        int br;
        int hlt;
        int wr_off;
        int wr_sig;
        int dec_sig;
        int ret;
    } exp_t;

    task automatic check(string name, int ln, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s lane%0d: got %0d expected %0d at %0t", name, ln, act, exp, $time);
        end
    endtask

    function automatic bit model_taken(decoded_instruction_type i, bit be, bit z, bit n, bit v);
        if (!be) return 1'b0;
        case (i)
            I_BRANCH: return 1'b1;
            I_BZERO:  return z;
            I_BNZERO: return !z;
            I_BNEG:   return n;
            I_BNNEG:  return !n;
            I_BOV:    return v;
            I_BNOV:   return !v;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic int model_op(decoded_instruction_type i);
        case (i)
            I_ADD:   return 1;
            I_SUB:   return 2;
            I_AND:   return 3;
            default: return 0;
        endcase
    endfunction

    // Signatures are {addr_sel, c_sel, operation[1:0]} as an integer.
    function automatic exp_t model_expect(decoded_instruction_type i, bit taken,
                                          int rl, int h, int ret);
        exp_t e;
        e = '{default: 0};
        e.pc = 1;
        e.wr_off = -1;
        e.ret = ret;
        case (i)
            I_ADD, I_SUB, I_AND, I_OR, I_MOVE: begin
                e.lat = 4; e.wr = 1; e.wr_off = 2;
                e.flg = (i != I_MOVE) ? 1 : 0;
                e.wr_sig = 4 + model_op(i);
                e.dec_sig = 4 + model_op(i);
            end
            I_LOAD: begin
                e.lat = 4 + rl; e.wr = 1; e.wr_off = 2 + rl;
                e.wr_sig = 8; e.dec_sig = 8;
            end
            I_STORE: begin
                e.lat = 4; e.ram = 1; e.dec_sig = 8;
            end
            I_HALT: begin
                e.lat = 3 + h; e.hlt = h;
            end
            default: begin
                if (taken) begin
                    e.lat = 4; e.pc = 2; e.br = 1;
                end else begin
                    e.lat = 3;
                end
            end
        endcase
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int unsigned RL = (g == 0) ? 3 : 0;
        localparam int unsigned CW = (g == 0) ? 16 : 2;
        localparam bit          BE = (g == 0);
        localparam int          MAXC = (1 << CW) - 1;

        decoded_instruction_type instr = I_NOP;
        logic zero_op = 1'b0, neg_op = 1'b0, uov = 1'b0, sov = 1'b0, resume = 1'b0;
        logic branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel;
        logic flags_reg_enable, ram_write_enable, halt;
        logic [1:0] operation;
        logic [CW-1:0] retired_count;
        logic [10:0] all_outs;

        assign all_outs = {branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
                           operation, flags_reg_enable, ram_write_enable, halt};

        multicycle_control_unit #(
            .RAM_LATENCY(RL),
            .CNT_WIDTH(CW),
            .BRANCH_EN(BE)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .decoded_instruction(instr),
            .zero_op(zero_op),
            .neg_op(neg_op),
            .unsigned_overflow(uov),
            .signed_overflow(sov),
            .resume(resume),
            .branch(branch),
            .pc_enable(pc_enable),
            .ir_enable(ir_enable),
            .write_reg_enable(write_reg_enable),
            .addr_sel(addr_sel),
            .c_sel(c_sel),
            .operation(operation),
            .flags_reg_enable(flags_reg_enable),
            .ram_write_enable(ram_write_enable),
            .halt(halt),
            .retired_count(retired_count)
        );

        exp_t q[$];
        int nrec = 0;
        int model_ret = 0;
        int hold_len = 1;
        int hcnt = 0;
        bit hold_flags = 1'b0;

        // Stimulus: acts as the IR, loading a new instruction when ir_enable is seen,
        // and holds the flags steady through the following DECODE cycle.
        always @(negedge clk) begin : feeder
            decoded_instruction_type ni;
            int h;
            if (!rst_n) begin
                model_ret = 0;
                hold_flags = 1'b0;
                resume = 1'b0;
                hcnt = 0;
            end else begin
                if (halt) begin
                    hcnt++;
                    resume = (hcnt == hold_len);
                end else begin
                    hcnt = 0;
                    resume = 1'b0;
                end
                if (ir_enable) begin
                    ni = (g == 0 && pre_reset_phase) ? I_LOAD
                         : decoded_instruction_type'(4'($urandom_range(0, 15)));
                    {zero_op, neg_op, uov, sov} = 4'($urandom);
                    h = ($urandom_range(0, 3) == 0) ? 10 : int'($urandom_range(1, 6));
                    if (ni == I_HALT) hold_len = h;
                    model_ret = (model_ret < MAXC) ? model_ret + 1 : MAXC;
                    q.push_back(model_expect(ni, model_taken(ni, BE, zero_op, neg_op, sov),
                                             int'(RL), h, model_ret));
                    instr = ni;
                    hold_flags = 1'b1;
                end else if (hold_flags) begin
                    hold_flags = 1'b0;
                end else begin
                    {zero_op, neg_op, uov, sov} = 4'($urandom);
                end
            end
        end

        bit open = 1'b0;
        int cyc, pc_n, wr_n, ram_n, flg_n, br_n, hlt_n, wr_off, wr_sig, dec_sig;

        // Monitor: one window per instruction, from its ir_enable to the next one.
        always @(negedge clk) begin : monitor
            exp_t e;
            if (!rst_n) begin
                q.delete();
                open = 1'b0;
            end else begin
                if (ir_enable) begin
                    if (open) begin
                        if (q.size() == 0) begin
                            check("scoreboard_nonempty", g, q.size(), 1);
                        end else begin
                            e = q.pop_front();
                            check("latency", g, cyc, e.lat);
                            check("pc_pulses", g, pc_n, e.pc);
                            check("wr_pulses", g, wr_n, e.wr);
                            check("ram_pulses", g, ram_n, e.ram);
                            check("flag_pulses", g, flg_n, e.flg);
                            check("branch_pulses", g, br_n, e.br);
                            check("halt_cycles", g, hlt_n, e.hlt);
                            check("wr_offset", g, wr_off, e.wr_off);
                            check("wr_steer", g, wr_sig, e.wr_sig);
                            check("decode_steer", g, dec_sig, e.dec_sig);
                            check("retired_count", g, int'(retired_count), e.ret);
                            nrec++;
                        end
                    end
                    open = 1'b1;
                    cyc = 0; pc_n = 0; wr_n = 0; ram_n = 0; flg_n = 0; br_n = 0; hlt_n = 0;
                    wr_off = -1; wr_sig = 0; dec_sig = 0;
                end
                if (open) begin
                    if (cyc == 1) dec_sig = int'({addr_sel, c_sel, operation});
                    pc_n += int'(pc_enable);
                    wr_n += int'(write_reg_enable);
                    ram_n += int'(ram_write_enable);
                    flg_n += int'(flags_reg_enable);
                    br_n += int'(branch);
                    hlt_n += int'(halt);
                    if (write_reg_enable) begin
                        wr_off = cyc;
                        wr_sig = int'({addr_sel, c_sel, operation});
                    end
                    cyc++;
                    if (cyc > 200) begin
                        check("instr_window_bound", g, cyc, 200);
                        open = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int done;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", 0, int'(lane[0].all_outs), 0);
        check("reset_outs", 1, int'(lane[1].all_outs), 0);
        check("reset_count", 0, int'(lane[0].retired_count), 0);
        check("reset_count", 1, int'(lane[1].retired_count), 0);

        rst_n = 1'b1;
        #1;
        check("fetch_after_release", 0, int'(lane[0].ir_enable), 0);
        @(negedge clk);
        check("latch_after_fetch", 0, int'(lane[0].ir_enable), 1);
        check("latch_after_fetch", 1, int'(lane[1].ir_enable), 1);
        @(negedge clk);
        @(negedge clk);
        check("mem_wait_addr_sel", 0, int'(lane[0].addr_sel), 1);
        check("mem_wait_no_wr", 0, int'(lane[0].write_reg_enable), 0);

        // Asynchronous reset in the middle of the LOAD wait states.
        #2 rst_n = 1'b0;
        pre_reset_phase = 1'b0;
        #1;
        check("async_reset_outs", 0, int'(lane[0].all_outs), 0);
        check("async_reset_outs", 1, int'(lane[1].all_outs), 0);
        check("async_reset_count", 0, int'(lane[0].retired_count), 0);
        check("async_reset_count", 1, int'(lane[1].retired_count), 0);
        @(negedge clk);
        check("held_in_reset_wr", 0, int'(lane[0].write_reg_enable), 0);
        @(negedge clk);
        rst_n = 1'b1;

        done = 0;
        for (int c = 0; c < 40000; c++) begin
            if (lane[0].nrec >= N_REC && lane[1].nrec >= N_REC) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        check("records_lane0", 0, (lane[0].nrec >= N_REC) ? N_REC : lane[0].nrec, N_REC);
        check("records_lane1", 1, (lane[1].nrec >= N_REC) ? N_REC : lane[1].nrec, N_REC);
        if (done == 1) begin
            check("saturated_count", 1, int'(lane[1].retired_count), 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
